// File: rtl/vram_pkg.sv
// +----------------------------------------------------------------------------+
// | vram_pkg : shared types and defaults for the video RAM arbiter             |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package vram_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 32;

  typedef enum logic [0:0] {
    REQ_VID = 1'b0,
    REQ_CPU = 1'b1
  } req_id_t;

  typedef enum logic [0:0] {
    VID_PRI   = 1'b0,
    CPU_FORCE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_tag_pipe.sv
// +----------------------------------------------------------------------------+
// | rsp_tag_pipe : fixed-depth shift register of read tags, async clear        |
// | Rev 1.0      : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rsp_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag
);

  logic [DEPTH-1:0][TAG_W-1:0] r_stage;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage <= '0;
        else        r_stage[0] <= i_tag;
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage <= '0;
        else        r_stage <= {r_stage[DEPTH-2:0], i_tag};
      end
    end
  endgenerate

  assign o_tag = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// +----------------------------------------------------------------------------+
// | vram_arbiter : VID-priority / CPU starvation-guarded single-port VRAM mux  |
// | Optional stall/forced-grant counters: define VRAM_ARB_STATS_EN             |
// | Rev 1.0      : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                vid_req_valid_in,
  output logic                vid_req_ready_out,
  input  logic [ADDR_W-1:0]   vid_addr_in,
  output logic                vid_rsp_valid_out,
  output logic [DATA_W-1:0]   vid_rsp_data_out,
  input  logic                cpu_req_valid_in,
  output logic                cpu_req_ready_out,
  input  logic                cpu_we_in,
  input  logic [DATA_W/8-1:0] cpu_wstrb_in,
  input  logic [ADDR_W-1:0]   cpu_addr_in,
  input  logic [DATA_W-1:0]   cpu_wdata_in,
  output logic                cpu_rsp_valid_out,
  output logic [DATA_W-1:0]   cpu_rsp_data_out,
  output logic                mem_en_out,
  output logic [DATA_W/8-1:0] mem_we_out,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic [DATA_W-1:0]   mem_wdata_out,
`ifdef VRAM_ARB_STATS_EN
  output logic [31:0]         cpu_stall_cycles_out,
  output logic [15:0]         forced_grants_out,
`endif
  input  logic [DATA_W-1:0]   mem_rdata_in
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_LIMIT);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt, w_starve_nxt;
  logic             w_vid_ready, w_cpu_ready;
  logic             w_vid_grant, w_cpu_grant;
  rd_tag_t          w_tag_in, w_tag_out;
  logic [TAG_W-1:0] w_tag_out_raw;

  // Ready is forced low while reset is asserted so no request is accepted.
  always_comb begin
    w_vid_ready  = 1'b0;
    w_cpu_ready  = 1'b0;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      VID_PRI: begin
        w_vid_ready = rst_n_in;
        w_cpu_ready = rst_n_in & ~vid_req_valid_in;
      end
      CPU_FORCE: w_cpu_ready = rst_n_in;
      default: ;
    endcase
    w_vid_grant = vid_req_valid_in & w_vid_ready;
    w_cpu_grant = cpu_req_valid_in & w_cpu_ready;
    if (w_cpu_grant)
      w_starve_nxt = '0;
    else if (cpu_req_valid_in && (r_starve_cnt != c_starve_max))
      w_starve_nxt = r_starve_cnt + 1'b1;
    // Switching on the upcoming count lets the forced grant land on the
    // cycle right after the STARVE_LIMIT-th lost cycle.
    case (r_state)
      VID_PRI:   if (w_starve_nxt == c_starve_max) w_state_nxt = CPU_FORCE;
      CPU_FORCE: if (w_cpu_grant) w_state_nxt = VID_PRI;
      default:   w_state_nxt = VID_PRI;
    endcase
  end

  assign vid_req_ready_out = w_vid_ready;
  assign cpu_req_ready_out = w_cpu_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= VID_PRI;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_en_out    <= 1'b0;
      mem_we_out    <= '0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
    end else begin
      mem_en_out <= w_vid_grant | w_cpu_grant;
      mem_we_out <= (w_cpu_grant && cpu_we_in) ? cpu_wstrb_in : '0;
      if (w_vid_grant) begin
        mem_addr_out <= vid_addr_in;
      end else if (w_cpu_grant) begin
        mem_addr_out  <= cpu_addr_in;
        mem_wdata_out <= cpu_wdata_in;
      end
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_vid_grant | (w_cpu_grant & ~cpu_we_in);
    w_tag_in.id    = w_vid_grant ? REQ_VID : REQ_CPU;
  end

  rsp_tag_pipe #(
    .DEPTH (1 + RD_LAT)
  ) u_tag_pipe (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out_raw)
  );

  assign w_tag_out = rd_tag_t'(w_tag_out_raw);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vid_rsp_valid_out <= 1'b0;
      vid_rsp_data_out  <= '0;
      cpu_rsp_valid_out <= 1'b0;
      cpu_rsp_data_out  <= '0;
    end else begin
      vid_rsp_valid_out <= w_tag_out.valid && (w_tag_out.id == REQ_VID);
      cpu_rsp_valid_out <= w_tag_out.valid && (w_tag_out.id == REQ_CPU);
      if (w_tag_out.valid && (w_tag_out.id == REQ_VID)) vid_rsp_data_out <= mem_rdata_in;
      if (w_tag_out.valid && (w_tag_out.id == REQ_CPU)) cpu_rsp_data_out <= mem_rdata_in;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_forced_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_stall_cnt  <= '0;
      r_forced_cnt <= '0;
    end else begin
      if (cpu_req_valid_in && !w_cpu_grant && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_cpu_grant && (r_state == CPU_FORCE) && !(&r_forced_cnt))
        r_forced_cnt <= r_forced_cnt + 1'b1;
    end
  end

  assign cpu_stall_cycles_out = r_stall_cnt;
  assign forced_grants_out    = r_forced_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_vram_arbiter : scoreboard bench with a write-first 2-cycle BRAM model   |
// | Rev 1.0         : initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          vid_req_valid_in, vid_req_ready_out;
  logic [AW-1:0] vid_addr_in;
  logic          vid_rsp_valid_out;
  logic [DW-1:0] vid_rsp_data_out;
  logic          cpu_req_valid_in, cpu_req_ready_out, cpu_we_in;
  logic [3:0]    cpu_wstrb_in;
  logic [AW-1:0] cpu_addr_in;
  logic [DW-1:0] cpu_wdata_in;
  logic          cpu_rsp_valid_out;
  logic [DW-1:0] cpu_rsp_data_out;
  logic          mem_en_out;
  logic [3:0]    mem_we_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_wdata_out;
  logic [DW-1:0] mem_rdata_in;
`ifdef VRAM_ARB_STATS_EN
  logic [31:0]   cpu_stall_cycles_out;
  logic [15:0]   forced_grants_out;
`endif

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_LIMIT(8)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .vid_req_valid_in  (vid_req_valid_in),
    .vid_req_ready_out (vid_req_ready_out),
    .vid_addr_in       (vid_addr_in),
    .vid_rsp_valid_out (vid_rsp_valid_out),
    .vid_rsp_data_out  (vid_rsp_data_out),
    .cpu_req_valid_in  (cpu_req_valid_in),
    .cpu_req_ready_out (cpu_req_ready_out),
    .cpu_we_in         (cpu_we_in),
    .cpu_wstrb_in      (cpu_wstrb_in),
    .cpu_addr_in       (cpu_addr_in),
    .cpu_wdata_in      (cpu_wdata_in),
    .cpu_rsp_valid_out (cpu_rsp_valid_out),
    .cpu_rsp_data_out  (cpu_rsp_data_out),
    .mem_en_out        (mem_en_out),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_wdata_out     (mem_wdata_out),
`ifdef VRAM_ARB_STATS_EN
    .cpu_stall_cycles_out (cpu_stall_cycles_out),
    .forced_grants_out    (forced_grants_out),
`endif
    .mem_rdata_in      (mem_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model: write-first, data valid two edges after mem_en_out.
  logic [DW-1:0] bram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd0, rd1;

  always @(posedge clk_in) begin
    if (mem_en_out) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_out[b]) bram[mem_addr_out][8*b +: 8] = mem_wdata_out[8*b +: 8];
      rd0 <= bram[mem_addr_out];
    end
    rd1 <= rd0;
  end
  assign mem_rdata_in = rd1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t vq[$];
  exp_t cq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   vid_pulses = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response side of the scoreboard: data and exact arrival cycle.
  always @(negedge clk_in) begin
    exp_t e;
    if (vid_rsp_valid_out) begin
      vid_pulses++;
      if (vq.size() == 0) check("vid_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = vq.pop_front();
        check("vid_rsp_data", vid_rsp_data_out, e.data);
        check("vid_rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (cpu_rsp_valid_out) begin
      if (cq.size() == 0) check("cpu_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = cq.pop_front();
        check("cpu_rsp_data", cpu_rsp_data_out, e.data);
        check("cpu_rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [3:0] strb);
    logic [DW-1:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic cpu_op(input logic we, input logic [3:0] strb, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int budget = 40;
    bit done = 0;
    @(negedge clk_in);
    cpu_req_valid_in = 1'b1; cpu_we_in = we; cpu_wstrb_in = strb;
    cpu_addr_in = a; cpu_wdata_in = d;
    while (!done && budget > 0) begin
      #1;
      if (cpu_req_ready_out) begin
        done = 1;
        if (we) ref_mem[a] = merge(ref_mem[a], d, strb);
        else    cq.push_back('{data: ref_mem[a], due: cyc + 4});
        @(posedge clk_in); #1;
        check("mem_en_issue", 32'(mem_en_out), 32'd1);
        check("mem_we_issue", 32'(mem_we_out), we ? 32'(strb) : 32'd0);
        check("mem_addr_issue", 32'(mem_addr_out), 32'(a));
      end
      @(negedge clk_in);
      budget--;
    end
    if (!done) check("cpu_grant_timeout", 32'd1, 32'd0);
    cpu_req_valid_in = 1'b0;
  endtask

  // Back-to-back VID reads; returns with valid dropped on a falling edge.
  task automatic vid_stream(input int start, input int n);
    @(negedge clk_in);
    for (int i = 0; i < n; i++) begin
      vid_req_valid_in = 1'b1;
      vid_addr_in = AW'(start + i);
      #1;
      check("vid_ready_stream", 32'(vid_req_ready_out), 32'd1);
      if (vid_req_ready_out) vq.push_back('{data: ref_mem[start + i], due: cyc + 4});
      @(negedge clk_in);
    end
    vid_req_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int vaddr;
    int cn;
    logic vg, cg;
    for (int i = 0; i < 256; i++) begin
      bram[i]    = 32'hA5000000 ^ (i * 32'h00010203);
      ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
    end
    rst_n_in = 1'b0;
    vid_req_valid_in = 1'b0; vid_addr_in = '0;
    cpu_req_valid_in = 1'b0; cpu_we_in = 1'b0; cpu_wstrb_in = '0;
    cpu_addr_in = '0; cpu_wdata_in = '0;
    #1;
    check("rst_vid_ready", 32'(vid_req_ready_out), 32'd0);
    check("rst_cpu_ready", 32'(cpu_req_ready_out), 32'd0);
    check("rst_mem_en", 32'(mem_en_out), 32'd0);
    check("rst_vid_rsp_valid", 32'(vid_rsp_valid_out), 32'd0);
    check("rst_cpu_rsp_data", cpu_rsp_data_out, 32'd0);
    wait_cycles(3);
    rst_n_in = 1'b1;
    #1;
    check("idle_vid_ready", 32'(vid_req_ready_out), 32'd1);

    // Write then read back the same word.
    cpu_op(1'b1, 4'hF, 17'h00010, 32'hDEADBEEF);
    cpu_op(1'b0, 4'h0, 17'h00010, 32'h0);
    wait_cycles(6);
    check("t1_ref_value", ref_mem[17'h10], 32'hDEADBEEF);

    // Sixteen consecutive VID reads.
    vid_stream(0, 16);
    wait_cycles(6);

    // Partial-byte write.
    cpu_op(1'b1, 4'hF, 17'h00020, 32'h11223344);
    cpu_op(1'b1, 4'b0010, 17'h00020, 32'h0000AB00);
    cpu_op(1'b0, 4'h0, 17'h00020, 32'h0);
    wait_cycles(6);
    check("t4_ref_value", ref_mem[17'h20], 32'h1122AB44);

    // Reset with three VID reads in flight.
    vid_stream(40, 3);
    rst_n_in = 1'b0;
    #1;
    check("midrst_vid_ready", 32'(vid_req_ready_out), 32'd0);
    check("midrst_cpu_ready", 32'(cpu_req_ready_out), 32'd0);
    check("midrst_mem_en", 32'(mem_en_out), 32'd0);
    vq.delete();
    base = vid_pulses;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("postrst_vid_ready", 32'(vid_req_ready_out), 32'd1);
    wait_cycles(8);
    check("postrst_no_vid_rsp", 32'(vid_pulses - base), 32'd0);

    // Contention: both valid for 90 cycles, CPU reads sequential words.
    vaddr = 0; cn = 0;
    @(negedge clk_in);
    vid_req_valid_in = 1'b1; vid_addr_in = '0;
    cpu_req_valid_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = AW'(128);
    for (int k = 1; k <= 90; k++) begin
      #1;
      vg = vid_req_valid_in & vid_req_ready_out;
      cg = cpu_req_valid_in & cpu_req_ready_out;
      check("both_granted", 32'(vg & cg), 32'd0);
      check("cpu_grant_slot", 32'(cg), 32'(k % 9 == 0));
      check("vid_grant_slot", 32'(vg), 32'(k % 9 != 0));
      if (vg) vq.push_back('{data: ref_mem[vaddr], due: cyc + 4});
      if (cg) cq.push_back('{data: ref_mem[128 + cn], due: cyc + 4});
      @(negedge clk_in);
      if (vg) begin vaddr++; vid_addr_in = AW'(vaddr); end
      if (cg) begin cn++; cpu_addr_in = AW'(128 + cn); end
    end
    vid_req_valid_in = 1'b0;
    cpu_req_valid_in = 1'b0;
`ifdef VRAM_ARB_STATS_EN
    #1;
    check("stats_forced", 32'(forced_grants_out), 32'd10);
    check("stats_stall", cpu_stall_cycles_out, 32'd80);
`endif
    wait_cycles(8);
    check("vid_pending_empty", 32'(vq.size()), 32'd0);
    check("cpu_pending_empty", 32'(cq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
